// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, opcodes and IR field layout.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_OP     = 7'b0110011;
    localparam opcode_t OP_OPIMM  = 7'b0010011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/instr_fetch_ir_fields.sv
// Combinational split of a 32-bit instruction word into its standard fields.
module ir_fields
    import riscv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    // Fixed-position slicing of the instruction word
    always_comb begin
        opcode = ir[OPCODE_LSB +: 7];
        rd     = ir[RD_LSB     +: 5];
        funct3 = ir[FUNCT3_LSB +: 3];
        rs1    = ir[RS1_LSB    +: 5];
        rs2    = ir[RS2_LSB    +: 5];
        funct7 = ir[FUNCT7_LSB +: 7];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch datapath: PC, memory request/handshake with timeout,
// one-word fetch buffer, instruction register and sticky fault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned        XLEN     = 64,
    parameter logic [XLEN-1:0]    RESET_PC = '0,
    parameter int unsigned        TIMEOUT  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            IMemRead,
    input  logic            PCWrite,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic            LoadIR,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_ir,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic            ir_valid,
    output logic            fetch_busy,
    output logic            fault
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_ir_q, pc_ir_d;
    logic [31:0]     ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            fault_q, fault_d;
    logic [31:0]     buf_q, buf_d;
    logic [XLEN-1:0] buf_addr_q, buf_addr_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   count_q, count_d;

    logic            aligned;
    logic            issue;

    // Next-state logic for the fetch FSM and datapath; memory request outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_ir_d    = pc_ir_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        buf_d      = buf_q;
        buf_addr_d = buf_addr_q;
        addr_d     = addr_q;
        pending_d  = pending_q;
        count_d    = count_q;

        aligned = (pc_q[1:0] == 2'b00);
        // A new fetch may start from IDLE, or from FULL when the buffer is
        // drained into IR in the same cycle; otherwise IMemRead is ignored.
        issue   = IMemRead & ((state_q == IDLE) | ((state_q == FULL) & LoadIR));

        mem_req  = reset & ((issue & aligned) | (state_q == WAIT));
        mem_addr = (state_q == WAIT) ? addr_q : pc_q;

        if ((state_q != FAULT) && PCWrite) begin
            pc_d = PCSrc ? branch_target : pc_q + XLEN'(4);
        end

        case (state_q)
            FULL: begin
                if (LoadIR) begin
                    ir_d       = buf_q;
                    pc_ir_d    = buf_addr_q;
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    if (pending_q | LoadIR) begin
                        ir_d       = mem_rdata;
                        pc_ir_d    = addr_q;
                        ir_valid_d = 1'b1;
                        pending_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        buf_d      = mem_rdata;
                        buf_addr_d = addr_q;
                        state_d    = FULL;
                    end
                end else begin
                    if (LoadIR) begin
                        pending_d = 1'b1;
                    end
                    if (count_q == CW'(TIMEOUT - 1)) begin
                        state_d   = FAULT;
                        fault_d   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase

        // Fetch start overrides the FULL->IDLE transition for back-to-back issue
        if (issue) begin
            if (!aligned) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else if (mem_ready) begin
                buf_d      = mem_rdata;
                buf_addr_d = pc_q;
                state_d    = FULL;
            end else begin
                addr_d    = pc_q;
                count_d   = '0;
                pending_d = 1'b0;
                state_d   = WAIT;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pc_ir_q    <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            buf_q      <= '0;
            buf_addr_q <= '0;
            addr_q     <= '0;
            pending_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_ir_q    <= pc_ir_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
            buf_q      <= buf_d;
            buf_addr_q <= buf_addr_d;
            addr_q     <= addr_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
        end
    end

    assign pc         = pc_q;
    assign pc_ir      = pc_ir_q;
    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign fault      = fault_q;
    assign fetch_busy = (state_q == WAIT) | pending_q;

    ir_fields u_ir_fields (
        .ir     (ir_q),
        .opcode (opcode),
        .rd     (rd),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct7 (funct7)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch;

    localparam int unsigned TO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        IMemRead = 1'b0, PCWrite = 1'b0, PCSrc = 1'b0, LoadIR = 1'b0;
    logic [63:0] branch_target = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [63:0] mem_addr, pc, pc_ir;
    logic [31:0] ir;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        ir_valid, fetch_busy, fault;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Memory content is a fixed function of the address; word at 0 is 00500093
    function automatic logic [31:0] memword(input logic [63:0] a);
        return a[31:0] ^ 32'h00500093;
    endfunction

    assign mem_rdata = memword(mem_addr);

    always #5 clock = ~clock;

    instr_fetch #(.XLEN(64), .RESET_PC(64'h0), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .IMemRead(IMemRead), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .branch_target(branch_target), .LoadIR(LoadIR),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .pc_ir(pc_ir), .ir(ir),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .ir_valid(ir_valid), .fetch_busy(fetch_busy), .fault(fault)
    );

    // Reference model: architectural view of the fetch unit
    logic [63:0] m_pc, m_pcir, m_oaddr, m_haddr;
    logic [31:0] m_ir, m_hword;
    logic        m_valid, m_fault, m_outst, m_want, m_held;
    int unsigned m_wait;

    logic        s_req;
    logic [63:0] s_addr;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_pcir = '0; m_ir = '0; m_valid = 1'b0; m_fault = 1'b0;
        m_outst = 1'b0; m_want = 1'b0; m_held = 1'b0; m_wait = 0;
        m_oaddr = '0; m_haddr = '0; m_hword = '0;
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model, cross posedge
    task automatic step(input logic rst_n, input logic imr, input logic pcw, input logic src,
                        input logic [63:0] bt, input logic lir, input logic rdy);
        logic        e_req, may_issue;
        logic [63:0] npc;
        reset = rst_n; IMemRead = imr; PCWrite = pcw; PCSrc = src;
        branch_target = bt; LoadIR = lir; mem_ready = rdy;
        @(negedge clock);
        may_issue = !m_fault && !m_outst && imr && (!m_held || lir);
        e_req = rst_n && (m_outst || (may_issue && m_pc[1:0] == 2'b00));
        s_req = mem_req; s_addr = mem_addr;
        chk("mem_req", {63'b0, mem_req}, {63'b0, e_req});
        if (e_req) chk("mem_addr", mem_addr, m_outst ? m_oaddr : m_pc);
        chk("pc", pc, m_pc);
        chk("pc_ir", pc_ir, m_pcir);
        chk("ir", {32'b0, ir}, {32'b0, m_ir});
        chk("fields", {32'b0, funct7, rs2, rs1, funct3, rd, opcode}, {32'b0, m_ir});
        chk("ir_valid", {63'b0, ir_valid}, {63'b0, m_valid});
        chk("fetch_busy", {63'b0, fetch_busy}, {63'b0, m_outst});
        chk("fault", {63'b0, fault}, {63'b0, m_fault});
        if (!rst_n) begin
            model_reset();
        end else if (!m_fault) begin
            npc = pcw ? (src ? bt : m_pc + 64'd4) : m_pc;
            if (m_outst) begin
                if (rdy) begin
                    if (m_want || lir) begin
                        m_ir = memword(m_oaddr); m_pcir = m_oaddr; m_valid = 1'b1;
                    end else begin
                        m_held = 1'b1; m_hword = memword(m_oaddr); m_haddr = m_oaddr;
                    end
                    m_outst = 1'b0; m_want = 1'b0;
                end else begin
                    if (lir) m_want = 1'b1;
                    if (m_wait == TO - 1) begin
                        m_fault = 1'b1; m_outst = 1'b0; m_want = 1'b0;
                    end else begin
                        m_wait++;
                    end
                end
            end else begin
                if (m_held && lir) begin
                    m_ir = m_hword; m_pcir = m_haddr; m_valid = 1'b1; m_held = 1'b0;
                end
                if (may_issue) begin
                    if (m_pc[1:0] != 2'b00) begin
                        m_fault = 1'b1;
                    end else if (rdy) begin
                        m_held = 1'b1; m_hword = memword(m_pc); m_haddr = m_pc;
                    end else begin
                        m_outst = 1'b1; m_oaddr = m_pc; m_wait = 0; m_want = 1'b0;
                    end
                end
            end
            m_pc = npc;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned n;
        logic [31:0] ir_save;
        logic [63:0] bt;

        model_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        chk("rst_pc", pc, 64'h0);
        chk("rst_ir", {32'b0, ir}, 64'h0);
        chk("rst_valid", {63'b0, ir_valid}, 64'h0);
        chk("rst_fault", {63'b0, fault}, 64'h0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Zero-wait fetch with PC advance, then load IR
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("t1_ir", {32'b0, ir}, 64'h00500093);
        chk("t1_pcir", pc_ir, 64'h0);
        chk("t1_pc", pc, 64'h4);
        chk("t1_opcode", {57'b0, opcode}, 64'h13);
        chk("t1_rd", {59'b0, rd}, 64'h1);
        chk("t1_valid", {63'b0, ir_valid}, 64'h1);

        // Three-cycle memory latency with LoadIR while waiting
        step(1, 1, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (fetch_busy) n++;
            step(1, 0, 0, 0, 0, (i == 0), (i == 2));
        end
        chk("t2_busy_cycles", 64'(n), 64'd3);
        chk("t2_busy_after", {63'b0, fetch_busy}, 64'h0);
        chk("t2_ir", {32'b0, ir}, 64'h00500097);
        chk("t2_pcir", pc_ir, 64'h4);

        // Branch then fetch from the target
        step(1, 0, 1, 1, 64'h100, 0, 0);
        step(1, 1, 1, 0, 0, 0, 1);
        chk("t3_req", {63'b0, s_req}, 64'h1);
        chk("t3_addr", s_addr, 64'h100);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("t3_pcir", pc_ir, 64'h100);
        chk("t3_pc", pc, 64'h104);
        chk("t3_ir", {32'b0, ir}, 64'h00500193);

        // Misaligned branch target faults on the next fetch
        ir_save = ir;
        step(1, 0, 1, 1, 64'h102, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t4_noreq", {63'b0, s_req}, 64'h0);
        chk("t4_fault", {63'b0, fault}, 64'h1);
        chk("t4_ir_kept", {32'b0, ir}, {32'b0, ir_save});
        step(1, 1, 1, 0, 0, 0, 1);
        chk("t4_pc_frozen", pc, 64'h102);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t4_rst_fault", {63'b0, fault}, 64'h0);

        // PC wraps; reset aborts an outstanding fetch
        step(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("t5_wrap", pc, 64'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("t5_busy", {63'b0, fetch_busy}, 64'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t5_req_in_rst", {63'b0, s_req}, 64'h0);
        chk("t5_valid", {63'b0, ir_valid}, 64'h0);
        chk("t5_busy_after", {63'b0, fetch_busy}, 64'h0);

        // Timeout: fault after TO waiting cycles; reset clears it
        step(1, 1, 1, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            n++;
            if (fault) break;
        end
        chk("t6_timeout_cycles", 64'(n), 64'd15);
        chk("t6_fault", {63'b0, fault}, 64'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_clear", {63'b0, fault}, 64'h0);
        chk("t6_pc", pc, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bt = {$urandom, $urandom};
            bt[1:0] = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
            step(($urandom_range(59) != 0),
                 ($urandom_range(1) == 0),
                 ($urandom_range(9) < 3),
                 ($urandom_range(1) == 0),
                 bt,
                 ($urandom_range(1) == 0),
                 ($urandom_range(9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch datapath consumed by the multicycle control FSM.
- Owns PC, issues instruction-memory reads on IMemRead, and advances PC on PCWrite (sequential or branch target).
- Buffers the returned word and loads the instruction register on LoadIR.
- Exposes IR fields to the decode/execute stages.
- Tolerates variable-latency memory via a ready handshake, with a timeout and fault reporting.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum cycles waiting for mem_ready before fault (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- IMemRead  in  1  start instruction fetch at current PC.
- PCWrite  in  1  update PC this cycle.
- PCSrc  in  1  0: PC+4, 1: branch_target (used only with PCWrite).
- branch_target  in  XLEN  next PC when PCSrc=1.
- LoadIR  in  1  transfer fetched word into IR.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  XLEN  read address.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  memory accepts/completes request this cycle.
- pc  out  XLEN  current PC register.
- pc_ir  out  XLEN  address of the instruction held in IR.
- ir  out  32  instruction register.
- opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7  out  slices of ir.
- ir_valid  out  1  IR holds a fetched instruction.
- fetch_busy  out  1  fetch outstanding (state WAIT, or LoadIR pending).
- fault  out  1  sticky: misaligned fetch or memory timeout.

Behaviour:
- Reset (reset=0 at a rising edge): pc=RESET_PC, ir=0, pc_ir=0, ir_valid=0, fault=0, buffer invalid, pending=0, timeout count=0, state=IDLE. Reset has priority over all inputs and aborts any outstanding fetch; mem_req=0 during reset.
- States: IDLE, WAIT, FULL, FAULT.
- mem_req is combinational: (IDLE or FULL) & IMemRead & pc[1:0]==0, or state==WAIT.
- mem_addr: pc while issuing from IDLE/FULL; latched addr_q while in WAIT.
- Memory samples mem_req/mem_addr at the rising edge; a request completes at the edge where mem_req & mem_ready.
- IDLE + IMemRead:
  - pc[1:0]!=0 → FAULT, fault=1, no request.
  - mem_ready=1 → buffer<=mem_rdata, buf_addr<=pc, FULL.
  - else addr_q<=pc, count<=0, WAIT.
- WAIT:
  - mem_ready → buffer loaded, then FULL; if pending, load ir directly (ir_valid=1, pending=0) and go to IDLE.
  - else count++; when count reaches TIMEOUT-1 without ready → FAULT.
- LoadIR:
  - In FULL: ir<=buffer, pc_ir<=buf_addr, ir_valid=1, go to IDLE; a same-cycle IMemRead starts a new fetch as from IDLE (back-to-back).
  - In WAIT: pending<=1.
  - In IDLE with no buffer: ignored, ir unchanged.
- IMemRead while in WAIT or FAULT: ignored.
- IMemRead in FULL without LoadIR: ignored; the buffer is kept.
- PCWrite is independent of state (except FAULT, where it is ignored): pc<=PCSrc ? branch_target : pc+4, mod 2^XLEN (wraps silently). The fetch address is the PC before same-cycle update, so busca (PCWrite=IMemRead=1) fetches the old PC.
- A misaligned branch target is loaded without error; the fault is raised at the next IMemRead.
- FAULT is sticky until reset: mem_req=0, ir/pc frozen, fault=1.
- Timing with zero-wait memory under busca/salvaInstrucao alternation: IMemRead at edge N, LoadIR at N+1, ir valid after N+1, i.e. one instruction per 2 cycles with no stall.

Decomposition:
- Package riscv_pkg holds:
  - fetch_state_t enum (IDLE, WAIT, FULL, FAULT).
  - Opcode typedef/constants (OP_LOAD 7'b0000011, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH, OP_JAL, OP_LUI…).
  - Field bit-position constants.
  - NOP = 32'h00000013 for bench use.
- Sub-module ir_fields: purely combinational slicing of ir into opcode/rd/funct3/rs1/rs2/funct7, reused later by decode.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory returning 32'h00500093 → IMemRead+PCWrite then LoadIR: ir=00500093, pc_ir=0, pc=4, opcode=7'h13, rd=1, ir_valid=1.
- Memory ready delayed 3 cycles, LoadIR asserted while WAIT → fetch_busy=1 for 3 cycles; ir loads on the ready edge; state returns to IDLE.
- PCWrite with PCSrc=1, branch_target=0x100, then fetch → mem_addr=0x100, pc_ir=0x100, pc=0x104.
- Branch to 0x102, then IMemRead → mem_req never asserted, fault=1, ir unchanged, PCWrite ignored afterwards.
- mem_ready held 0 with TIMEOUT=15 → fault rises on the 15th WAIT cycle; reset=0 for one edge clears fault and pc=RESET_PC.
- pc=2^XLEN-4 with sequential PCWrite → pc=0 (wrap); reset asserted mid-WAIT → mem_req=0, ir_valid=0 next cycle.
